alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multi-cycle execution unit that consumes the 5-bit ALU operation code and Sign bit produced by the ALU control decoder, together with two 32-bit operands and a shift amount. It produces a result, a zero flag, an overflow flag and an illegal-op flag. Logical, arithmetic, compare and LUI operations complete in one cycle. Shifts run one bit per cycle. The unit sits between the register-read stage and writeback, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported (LUI shifts by 16).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept; high only in IDLE.
- alu_ctrl  in  5  operation code, encoding below.
- sign  in  1  signed-arithmetic flag; only affects overflow for ADD/SUB.
- op_a, op_b  in  WIDTH  operands.
- shamt  in  5  shift amount for SLL/SRL/SRA.
- out_valid  out  1  result held stable until taken.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow, ADD/SUB with sign=1 only.
- illegal  out  1  alu_ctrl is not a defined code.

## Operation
- Codes and results:
  - 00000 ADD: a+b.
  - 00001 SUB: a-b.
  - 00010 AND.
  - 00011 OR.
  - 00100 XOR.
  - 00101 NOR.
  - 00110 SLL: b<<shamt.
  - 00111 SRL: b>>shamt, logical.
  - 01000 SRA: b>>>shamt, arithmetic.
  - 01001 SLTS: signed a<b gives 1, else 0.
  - 01010 SLTU: unsigned a<b gives 1, else 0.
  - 01011 BEQ: a-b, so zero=1 iff a==b.
  - 01100 LUI: b<<16.
  - Every other code, including 11111: result=0, illegal=1.
- For SLTS and SLTU the comparison type comes from alu_ctrl; sign is ignored.
- Overflow: ADD flags when the operands share a sign and the result sign differs. SUB flags when the operands differ in sign and the result sign differs from a. The flag is forced to 0 when sign=0 and for all other ops.
- All arithmetic wraps modulo 2^32.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch all inputs. A shift with shamt>0 goes to SHIFT; everything else computes its result and goes to DONE.
  - SHIFT: shift the working register by 1 bit per cycle and decrement the counter. When the counter reaches 0, go to DONE.
  - DONE: out_valid=1 and outputs held. On out_ready go to IDLE.
- Inputs are sampled only at acceptance; later changes on the input ports have no effect.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State returns to IDLE.
  - out_valid, result, zero, overflow and illegal all go to 0.
  - in_ready is 1 from the first edge after release.
- Reset mid-SHIFT or mid-DONE aborts the operation. The result is lost and out_valid drops immediately.
- Latency from the accept edge to out_valid high:
  - 1 cycle for non-shift ops and for shamt=0.
  - shamt+1 cycles for shifts; shamt=31 gives 32 cycles.
- Throughput: at most one operation in flight. in_ready is 0 in SHIFT and DONE.
- DONE with out_ready=1: out_valid drops on the next edge and in_ready rises in the same cycle. There is no same-cycle accept, so back-to-back ops have 2 cycles minimum spacing.
- out_valid must not drop without an out_ready handshake, except on reset.
- zero and overflow are registered with result and valid exactly when out_valid is high.

## Structure
- Shared package alu_pkg holds:
  - localparams for all 5-bit alu_ctrl codes (ALU_ADD … ALU_LUI, ALU_OTHER=5'b11111);
  - the FSM state typedef {IDLE, SHIFT, DONE}.
- The decoder and this unit both import alu_pkg.
- One sub-module, alu_shift_iter: working register, 5-bit counter, direction and arithmetic-fill control, and a done pulse.
- Single-cycle ops are combinational inside alu_exec_unit, registered on entry to DONE.

## Test plan
- ADD, sign=1, a=0x7FFFFFFF, b=1 → result 0x80000000, overflow=1, out_valid 1 cycle after accept. The same op with sign=0 → overflow=0.
- SUB and BEQ, a=b=0x1234 → result 0, zero=1. SLTS a=0xFFFFFFFF, b=1 → 1. SLTU with the same operands → 0.
- SRA, b=0x80000000, shamt=31 → result 0xFFFFFFFF after 32 cycles, in_ready=0 throughout. SLL with shamt=0 → result=b after 1 cycle.
- LUI b=0x0000ABCD → 0xABCD0000. alu_ctrl=11111 → result 0, illegal=1.
- Hold out_ready=0 for 10 cycles in DONE → outputs stable and in_ready=0. Release → in_ready=1 the next cycle. A second op accepted then completes correctly.
- Assert rst_n=0 at cycle 5 of SRL shamt=20 → out_valid=0 and in_ready=1 after release, with no stale result ever presented.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the ALU execution unit:
// operation codes, FSM state type and an op-class helper.
package alu_pkg;

   localparam logic [4:0] ALU_ADD   = 5'b00000;
   localparam logic [4:0] ALU_SUB   = 5'b00001;
   localparam logic [4:0] ALU_AND   = 5'b00010;
   localparam logic [4:0] ALU_OR    = 5'b00011;
   localparam logic [4:0] ALU_XOR   = 5'b00100;
   localparam logic [4:0] ALU_NOR   = 5'b00101;
   localparam logic [4:0] ALU_SLL   = 5'b00110;
   localparam logic [4:0] ALU_SRL   = 5'b00111;
   localparam logic [4:0] ALU_SRA   = 5'b01000;
   localparam logic [4:0] ALU_SLTS  = 5'b01001;
   localparam logic [4:0] ALU_SLTU  = 5'b01010;
   localparam logic [4:0] ALU_BEQ   = 5'b01011;
   localparam logic [4:0] ALU_LUI   = 5'b01100;
   localparam logic [4:0] ALU_OTHER = 5'b11111;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   function automatic logic is_shift(input logic [4:0] ctrl);
      return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle between the register-read stage, the ALU
// execution unit and writeback.
interface alu_exec_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       alu_ctrl;
   logic             sign;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [4:0]       shamt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;
   logic             illegal;

   modport master (
      output in_valid, alu_ctrl, sign, op_a, op_b, shamt, out_ready,
      input  in_ready, out_valid, result, zero, overflow, illegal
   );

   modport slave (
      input  in_valid, alu_ctrl, sign, op_a, op_b, shamt, out_ready,
      output in_ready, out_valid, result, zero, overflow, illegal
   );
endinterface

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter. done is high in the cycle before the
// final shift, so the caller can capture value_next on that edge.
module alu_shift_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [4:0]       load_count,
   input  logic             right,
   input  logic             arith,
   output logic [WIDTH-1:0] value_next,
   output logic             done
);
   logic [WIDTH-1:0] value;
   logic [4:0]       count;
   logic             busy;
   logic             dir_right;
   logic             fill_arith;

   always_comb begin
      value_next = {value[WIDTH-2:0], 1'b0};
      if (dir_right) begin
         value_next = {fill_arith & value[WIDTH-1], value[WIDTH-1:1]};
      end
   end

   assign done = busy && (count == 5'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value      <= '0;
         count      <= '0;
         busy       <= 1'b0;
         dir_right  <= 1'b0;
         fill_arith <= 1'b0;
      end else if (load) begin
         value      <= load_value;
         count      <= load_count;
         busy       <= (load_count != 5'd0);
         dir_right  <= right;
         fill_arith <= arith;
      end else if (busy) begin
         value <= value_next;
         count <= count - 5'd1;
         if (count == 5'd1) begin
            busy <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit: single-cycle logic/arith/compare/LUI ops,
// iterative shifts, valid/ready handshakes on both sides.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic             clk,
   input logic             rst_n,
   alu_exec_unit_if.slave  bus
);
   state_t           state, state_next;
   logic [WIDTH-1:0] a, b, alu_res, shift_next, result_q;
   logic             alu_ovf, alu_ill, zero_q, ovf_q, ill_q;
   logic             shift_load, shift_done, capture_alu, capture_shift, clear;

   assign a = bus.op_a;
   assign b = bus.op_b;

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (bus.alu_ctrl)
         ALU_ADD: begin
            alu_res = a + b;
            alu_ovf = bus.sign && (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_res = a - b;
            alu_ovf = bus.sign && (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_AND:  alu_res = a & b;
         ALU_OR:   alu_res = a | b;
         ALU_XOR:  alu_res = a ^ b;
         ALU_NOR:  alu_res = ~(a | b);
         // Only reached here with shamt == 0; non-zero shifts use the iterator.
         ALU_SLL, ALU_SRL, ALU_SRA: alu_res = b;
         ALU_SLTS: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         ALU_BEQ:  alu_res = a - b;
         ALU_LUI:  alu_res = {b[WIDTH-17:0], 16'h0000};
         default:  alu_ill = 1'b1;
      endcase
   end

   alu_shift_iter #(.WIDTH(WIDTH)) u_shift (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (shift_load),
      .load_value (bus.op_b),
      .load_count (bus.shamt),
      .right      (bus.alu_ctrl != ALU_SLL),
      .arith      (bus.alu_ctrl == ALU_SRA),
      .value_next (shift_next),
      .done       (shift_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      shift_load    = 1'b0;
      capture_alu   = 1'b0;
      capture_shift = 1'b0;
      clear         = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               if (is_shift(bus.alu_ctrl) && (bus.shamt != 5'd0)) begin
                  shift_load = 1'b1;
                  state_next = SHIFT;
               end else begin
                  capture_alu = 1'b1;
                  state_next  = DONE;
               end
            end
         end
         SHIFT: begin
            if (shift_done) begin
               capture_shift = 1'b1;
               state_next    = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               clear      = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else if (capture_alu) begin
         result_q <= alu_res;
         zero_q   <= (alu_res == '0);
         ovf_q    <= alu_ovf;
         ill_q    <= alu_ill;
      end else if (capture_shift) begin
         result_q <= shift_next;
         zero_q   <= (shift_next == '0);
         ovf_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else if (clear) begin
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ill_q    <= 1'b0;
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = ovf_q;
   assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, handshake and
// reset sequences, and random ops against a behavioural model.
module tb_alu_exec_unit;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_exec_unit_if #(.WIDTH(32)) bus ();
   alu_exec_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [4:0]  ctrl;
      logic        sign;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  shamt;
   } op_t;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ovf;
      logic        ill;
      int          lat;
   } exp_t;

   typedef struct {
      string name;
      op_t   op;
      exp_t  e;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [4:0] ctrl, input logic sign,
                               input logic [31:0] a, input logic [31:0] b, input logic [4:0] shamt,
                               input logic [31:0] res, input logic z, input logic o, input logic i,
                               input int lat);
      vec_t v;
      v.name = name;
      v.op.ctrl = ctrl; v.op.sign = sign; v.op.a = a; v.op.b = b; v.op.shamt = shamt;
      v.e.res = res; v.e.zero = z; v.e.ovf = o; v.e.ill = i; v.e.lat = lat;
      return v;
   endfunction

   // Reference model: integer arithmetic on the operation definitions.
   function automatic exp_t model(input op_t op);
      exp_t e;
      longint sa, sb, sum, dif;
      longint maxs, mins;
      logic signed [31:0] sbv;
      maxs = 64'sd2147483647;
      mins = -maxs - 64'sd1;
      sa  = longint'($signed(op.a));
      sb  = longint'($signed(op.b));
      sum = sa + sb;
      dif = sa - sb;
      sbv = op.b;
      e.res = 32'h0; e.ovf = 1'b0; e.ill = 1'b0;
      case (op.ctrl)
         5'd0:  begin e.res = op.a + op.b; e.ovf = op.sign && (sum > maxs || sum < mins); end
         5'd1:  begin e.res = op.a - op.b; e.ovf = op.sign && (dif > maxs || dif < mins); end
         5'd2:  e.res = op.a & op.b;
         5'd3:  e.res = op.a | op.b;
         5'd4:  e.res = op.a ^ op.b;
         5'd5:  e.res = ~(op.a | op.b);
         5'd6:  e.res = op.b << op.shamt;
         5'd7:  e.res = op.b >> op.shamt;
         5'd8:  e.res = sbv >>> op.shamt;
         5'd9:  e.res = (sa < sb) ? 32'd1 : 32'd0;
         5'd10: e.res = (op.a < op.b) ? 32'd1 : 32'd0;
         5'd11: e.res = op.a - op.b;
         5'd12: e.res = 32'(longint'(op.b) * 65536);
         default: e.ill = 1'b1;
      endcase
      e.zero = (e.res == 32'h0);
      e.lat  = (op.ctrl >= 5'd6 && op.ctrl <= 5'd8 && op.shamt != 5'd0) ? int'(op.shamt) + 1 : 1;
      return e;
   endfunction

   task automatic drive_op(input op_t op);
      bus.in_valid = 1'b1;
      bus.alu_ctrl = op.ctrl;
      bus.sign     = op.sign;
      bus.op_a     = op.a;
      bus.op_b     = op.b;
      bus.shamt    = op.shamt;
      @(posedge clk); #1;
      // Scramble inputs after acceptance; the unit must ignore them.
      bus.in_valid = 1'b0;
      bus.alu_ctrl = 5'($urandom);
      bus.sign     = 1'($urandom);
      bus.op_a     = $urandom;
      bus.op_b     = $urandom;
      bus.shamt    = 5'($urandom);
   endtask

   task automatic run_op(input string name, input op_t op, input exp_t e, input int hold);
      int   n;
      logic ready_bad;
      logic stable_bad;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check({name, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
      drive_op(op);
      n = 1;
      ready_bad = 1'b0;
      while (bus.out_valid !== 1'b1 && n < 64) begin
         if (bus.in_ready !== 1'b0) ready_bad = 1'b1;
         @(posedge clk); #1; n++;
      end
      check({name, " latency"}, 32'(n), 32'(e.lat));
      check({name, " in_ready busy"}, 32'(ready_bad), 32'd0);
      check({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, " result"}, bus.result, e.res);
      check({name, " zero"}, 32'(bus.zero), 32'(e.zero));
      check({name, " overflow"}, 32'(bus.overflow), 32'(e.ovf));
      check({name, " illegal"}, 32'(bus.illegal), 32'(e.ill));
      if (hold > 0) begin
         stable_bad = 1'b0;
         repeat (hold) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== e.res ||
                bus.zero !== e.zero || bus.overflow !== e.ovf || bus.illegal !== e.ill)
               stable_bad = 1'b1;
         end
         check({name, " held stable"}, 32'(stable_bad), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({name, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
      check({name, " in_ready after take"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      vec_t vecs[$];
      op_t  op;
      exp_t e;
      logic stale;

      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.alu_ctrl = '0; bus.sign = 1'b0;
      bus.op_a = '0; bus.op_b = '0; bus.shamt = '0; bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset result", bus.result, 32'h0);
      check("reset zero", 32'(bus.zero), 32'd0);
      check("reset overflow", 32'(bus.overflow), 32'd0);
      check("reset illegal", 32'(bus.illegal), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready after release", 32'(bus.in_ready), 32'd1);

      vecs.push_back(mk("add s1 ovf",  ALU_ADD, 1'b1, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1));
      vecs.push_back(mk("add s0",      ALU_ADD, 1'b0, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk("sub eq",      ALU_SUB, 1'b1, 32'h1234, 32'h1234, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1));
      vecs.push_back(mk("sub s1 ovf",  ALU_SUB, 1'b1, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1));
      vecs.push_back(mk("sub s0",      ALU_SUB, 1'b0, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk("beq eq",      ALU_BEQ, 1'b1, 32'h1234, 32'h1234, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1));
      vecs.push_back(mk("beq ne",      ALU_BEQ, 1'b1, 32'h5, 32'h7, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk("and",         ALU_AND, 1'b0, 32'hA5A5A5A5, 32'h0F0F0F0F, 5'd0, 32'h05050505, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk("or",          ALU_OR,  1'b0, 32'hF0, 32'h0F, 5'd0, 32'hFF, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk("nor",         ALU_NOR, 1'b0, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk("slts",        ALU_SLTS, 1'b0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk("sltu",        ALU_SLTU, 1'b1, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1));
      vecs.push_back(mk("sra 31",      ALU_SRA, 1'b0, 32'h0, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32));
      vecs.push_back(mk("sll 0",       ALU_SLL, 1'b0, 32'h0, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk("sll 31",      ALU_SLL, 1'b0, 32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0, 1'b0, 1'b0, 32));
      vecs.push_back(mk("srl 4",       ALU_SRL, 1'b0, 32'h0, 32'hF0000000, 5'd4, 32'h0F000000, 1'b0, 1'b0, 1'b0, 5));
      vecs.push_back(mk("sra 1 pos",   ALU_SRA, 1'b0, 32'h0, 32'h40000000, 5'd1, 32'h20000000, 1'b0, 1'b0, 1'b0, 2));
      vecs.push_back(mk("lui",         ALU_LUI, 1'b0, 32'h0, 32'h0000ABCD, 5'd0, 32'hABCD0000, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk("illegal 1f",  ALU_OTHER, 1'b1, 32'h5, 32'h6, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1));
      vecs.push_back(mk("illegal 0d",  5'b01101, 1'b0, 32'h5, 32'h6, 5'd3, 32'h0, 1'b1, 1'b0, 1'b1, 1));

      foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].e, 0);

      // Consumer stalls in DONE, then a second op follows immediately.
      op.ctrl = ALU_ADD; op.sign = 1'b0; op.a = 32'd100; op.b = 32'd23; op.shamt = 5'd0;
      e.res = 32'd123; e.zero = 1'b0; e.ovf = 1'b0; e.ill = 1'b0; e.lat = 1;
      run_op("hold10", op, e, 10);
      op.ctrl = ALU_XOR; op.a = 32'hFF00FF00; op.b = 32'h0F0F0F0F;
      e.res = 32'hF00FF00F;
      run_op("after hold", op, e, 0);

      // Reset during a shift: no result may surface afterwards.
      op.ctrl = ALU_SRL; op.sign = 1'b0; op.a = 32'h0; op.b = 32'hFFFF0000; op.shamt = 5'd20;
      drive_op(op);
      repeat (4) begin @(posedge clk); #1; end
      check("srl mid out_valid", 32'(bus.out_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid-shift reset out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("mid-shift reset in_ready", 32'(bus.in_ready), 32'd1);
      stale = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0 || bus.result !== 32'h0) stale = 1'b1;
      end
      check("no stale after reset", 32'(stale), 32'd0);

      // Reset while a result waits in DONE.
      op.ctrl = ALU_OR; op.a = 32'h1; op.b = 32'h2; op.shamt = 5'd0;
      drive_op(op);
      check("pre-reset done valid", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("done reset out_valid", 32'(bus.out_valid), 32'd0);
      check("done reset result", bus.result, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 5) == 0) op.ctrl = 5'($urandom_range(13, 31));
         else                           op.ctrl = 5'($urandom_range(0, 12));
         op.sign  = 1'($urandom);
         op.a     = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
         op.b     = ($urandom_range(0, 3) == 0) ? op.a : $urandom;
         op.shamt = 5'($urandom);
         e = model(op);
         run_op($sformatf("rand%0d op%0d", k, op.ctrl), op, e, $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
